// File: rtl/cic_comp_pkg.sv
// Package for the CIC droop-compensation FIR.
// Holds the default parameter values, the default compensation coefficient
// set (2**16 = unity gain), the FSM state type and the shared
// round/saturate helper used by each channel's MAC.
package cic_comp_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_COEF_WIDTH = 18;
  localparam int DEF_TAPS       = 21;
  localparam int DEF_OUT_SHIFT  = 16;

  typedef logic signed [DEF_COEF_WIDTH-1:0] coef_t;

  // Index 0 multiplies the newest sample; taps sum to 65536 (unity DC gain).
  localparam coef_t COMP_COEFS [DEF_TAPS] = '{
    -18'sd40,   18'sd120,  -18'sd260,  18'sd480,   -18'sd820,
     18'sd1320, -18'sd2050, 18'sd3100, -18'sd4700,  18'sd7600,
     18'sd56036,
     18'sd7600, -18'sd4700, 18'sd3100, -18'sd2050,  18'sd1320,
    -18'sd820,   18'sd480, -18'sd260,   18'sd120,  -18'sd40
  };

  typedef enum logic [1:0] {IDLE, MAC, ROUND} fsm_state_t;

  // Round half up, arithmetic shift, then clamp to a signed 'width'-bit range.
  // The accumulator arrives sign-extended to 64 bits, so acc + half cannot wrap.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int width);
    logic signed [63:0] rounded;
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
    if (shift > 0) rounded = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    else           rounded = acc;
    max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_val = -(64'sd1 <<< (width - 1));
    if (rounded > max_val)      sat_round = max_val;
    else if (rounded < min_val) sat_round = min_val;
    else                        sat_round = rounded;
  endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// Sample stream bundle for the CIC compensation FIR.
// master: producer side (drives i_* samples/strobe, observes o_* results).
// slave : the filter (consumes i_*, drives o_*).
//   i_inph_data/i_quad_data  signed input I/Q sample
//   i_valid                  one-cycle input strobe
//   o_inph_data/o_quad_data  signed filtered I/Q
//   o_valid                  one-cycle output strobe
//   o_overrun                one-cycle pulse, input dropped while busy
interface cic_comp_fir_if #(parameter int WIDTH = 16);
  logic signed [WIDTH-1:0] i_inph_data;
  logic signed [WIDTH-1:0] i_quad_data;
  logic                    i_valid;
  logic signed [WIDTH-1:0] o_inph_data;
  logic signed [WIDTH-1:0] o_quad_data;
  logic                    o_valid;
  logic                    o_overrun;

  modport master (output i_inph_data, i_quad_data, i_valid,
                  input  o_inph_data, o_quad_data, o_valid, o_overrun);
  modport slave  (input  i_inph_data, i_quad_data, i_valid,
                  output o_inph_data, o_quad_data, o_valid, o_overrun);
endinterface

// File: rtl/cic_comp_mac.sv
// One channel of the compensation FIR: registered product, accumulator and
// round/saturate result register, sequenced by strobes from the top FSM.
//   i_clock, i_reset  clock, synchronous active-high reset
//   clear             zero the accumulator (new sample accepted)
//   enable            register coef*sample this cycle
//   last              load the rounded, saturated accumulator into result
//   sample, coef      current delay-line entry and its coefficient
//   result            rounded/saturated filter output
module cic_comp_mac import cic_comp_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int TAPS       = DEF_TAPS,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic                         last,
  input  logic signed [WIDTH-1:0]      sample,
  input  logic signed [COEF_WIDTH-1:0] coef,
  output logic signed [WIDTH-1:0]      result
);

  localparam int PROD_W = WIDTH + COEF_WIDTH;
  localparam int ACC_W  = WIDTH + COEF_WIDTH + $clog2(TAPS);

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;
  logic signed [ACC_W-1:0]  acc;
  logic signed [63:0]       acc_ext;

  assign sample_ext = {{COEF_WIDTH{sample[WIDTH-1]}}, sample};
  assign coef_ext   = {{WIDTH{coef[COEF_WIDTH-1]}}, coef};
  assign acc_ext    = {{(64-ACC_W){acc[ACC_W-1]}}, acc};

  // The product is registered one cycle ahead of accumulation, so prod_valid
  // trails enable and the final product is absorbed in the first ROUND cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      result     <= '0;
    end else begin
      prod_valid <= enable;
      if (enable) prod <= sample_ext * coef_ext;
      if (clear)           acc <= '0;
      else if (prod_valid) acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      if (last) result <= WIDTH'(sat_round(acc_ext, OUT_SHIFT, WIDTH));
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR, I and Q, one time-multiplexed MAC per channel.
// Accepts one sample per TAPS+4 clocks; each accepted sample produces one
// output TAPS+3 clocks later. Samples arriving while busy are dropped and
// flagged on o_overrun.
//   i_clock, i_reset  clock, synchronous active-high reset
//   bus (slave)       i_inph_data, i_quad_data, i_valid in;
//                     o_inph_data, o_quad_data, o_valid, o_overrun out
module cic_comp_fir import cic_comp_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int TAPS       = DEF_TAPS,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT,
  parameter logic signed [COEF_WIDTH-1:0] COEFS [TAPS] = COMP_COEFS
) (
  input logic           i_clock,
  input logic           i_reset,
  cic_comp_fir_if.slave bus
);

  localparam int PTR_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  fsm_state_t              state;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        tap;
  logic [1:0]              round_cnt;
  logic signed [WIDTH-1:0] line_i [TAPS];
  logic signed [WIDTH-1:0] line_q [TAPS];
  logic signed [WIDTH-1:0] res_i;
  logic signed [WIDTH-1:0] res_q;
  logic                    accept;
  logic                    mac_en;
  logic                    mac_last;

  assign accept   = bus.i_valid && (state == IDLE);
  assign mac_en   = (state == MAC);
  assign mac_last = (state == ROUND) && (round_cnt == 2'd1);

  // ROUND spans three cycles: flush last product, round/saturate, present.
  // rd_ptr walks backwards from the newest entry so tap k sees x[n-k].
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tap             <= '0;
      round_cnt       <= '0;
      bus.o_inph_data <= '0;
      bus.o_quad_data <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_overrun   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        line_i[k] <= '0;
        line_q[k] <= '0;
      end
    end else begin
      bus.o_valid   <= 1'b0;
      bus.o_overrun <= bus.i_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            line_i[wr_ptr] <= bus.i_inph_data;
            line_q[wr_ptr] <= bus.i_quad_data;
            rd_ptr         <= wr_ptr;
            wr_ptr         <= (wr_ptr == PTR_W'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
            tap            <= '0;
            state          <= MAC;
          end
        end
        MAC: begin
          rd_ptr <= (rd_ptr == '0) ? PTR_W'(TAPS - 1) : rd_ptr - 1'b1;
          if (tap == PTR_W'(TAPS - 1)) begin
            round_cnt <= '0;
            state     <= ROUND;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        ROUND: begin
          round_cnt <= round_cnt + 1'b1;
          if (round_cnt == 2'd2) begin
            bus.o_inph_data <= res_i;
            bus.o_quad_data <= res_q;
            bus.o_valid     <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cic_comp_mac #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT)
  ) mac_inph (
    .i_clock(i_clock), .i_reset(i_reset), .clear(accept), .enable(mac_en),
    .last(mac_last), .sample(line_i[rd_ptr]), .coef(COEFS[tap]), .result(res_i)
  );

  cic_comp_mac #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT)
  ) mac_quad (
    .i_clock(i_clock), .i_reset(i_reset), .clear(accept), .enable(mac_en),
    .last(mac_last), .sample(line_q[rd_ptr]), .coef(COEFS[tap]), .result(res_q)
  );

endmodule
